// File: rtl/countdown_timer_pkg.sv
// Timekeeping constants, field layout and state encoding shared by countdown_timer and stopwatch.
package countdown_timer_pkg;

  localparam int HOUR_W  = 6;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int CS_W    = 8;
  localparam int EPOCH_W = HOUR_W + MIN_W + SEC_W;

  localparam logic [CS_W-1:0]  CS_MAX = 8'd99;
  localparam logic [SEC_W-1:0] SM_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUNNING = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_t;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [CS_W-1:0]   cs;
  } hms_t;

  // Clamp each field of a preset independently to its legal maximum.
  function automatic hms_t saturate(input logic [EPOCH_W-1:0] e,
                                    input logic [CS_W-1:0]    cs,
                                    input logic [HOUR_W-1:0]  hour_limit);
    hms_t t;
    t.hour = (e[17:12] > hour_limit) ? hour_limit : e[17:12];
    t.min  = (e[11:6] > SM_MAX) ? SM_MAX : e[11:6];
    t.sec  = (e[5:0] > SM_MAX) ? SM_MAX : e[5:0];
    t.cs   = (cs > CS_MAX) ? CS_MAX : cs;
    return t;
  endfunction

  function automatic logic is_zero(input hms_t t);
    return (t == '0);
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/preset inputs and time/status outputs of the countdown timer.
interface countdown_timer_if;
  import countdown_timer_pkg::*;

  logic               run;
  logic               load;
  logic [EPOCH_W-1:0] load_epoch;
  logic [CS_W-1:0]    load_m_epoch;
  logic [EPOCH_W-1:0] epoch;
  logic [CS_W-1:0]    m_epoch;
  logic               done;
  logic               alarm;

  modport master (
    output run, load, load_epoch, load_m_epoch,
    input  epoch, m_epoch, done, alarm
  );

  modport slave (
    input  run, load, load_epoch, load_m_epoch,
    output epoch, m_epoch, done, alarm
  );
endinterface

// File: rtl/countdown_timer_tick_divider.sv
// Prescaler producing a one-cycle tick every CLK_PER_TICK enabled cycles; holds while disabled.
module tick_divider #(
  parameter int CLK_PER_TICK = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_TICK - 1);

  logic [CW-1:0] count_reg;

  assign tick = enable && (count_reg == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= tick ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// hh:mm:ss.cc countdown timer: load/run FSM plus borrow-chain decrement on every prescaler tick.
module countdown_timer #(
  parameter int CLK_PER_TICK = 500000,
  parameter int HOUR_MAX     = 63
) (
  input  logic              clock,
  input  logic              reset,
  countdown_timer_if.slave  bus
);
  import countdown_timer_pkg::*;

  localparam logic [HOUR_W-1:0] HOUR_LIMIT = HOUR_W'(HOUR_MAX);

  timer_state_t state_reg, state_next;
  hms_t         cur_reg, cur_next;
  hms_t         dec_value;
  hms_t         load_value;
  logic         alarm_reg, alarm_next;
  logic         tick;
  timer_state_t run_state;

  tick_divider #(.CLK_PER_TICK(CLK_PER_TICK)) u_tick_divider (
    .clock  (clock),
    .reset  (reset),
    .clear  (bus.load),
    .enable (state_reg == ST_RUNNING),
    .tick   (tick)
  );

  assign load_value = saturate(bus.load_epoch, bus.load_m_epoch, HOUR_LIMIT);
  assign run_state  = bus.run ? ST_RUNNING : ST_ARMED;

  // Borrow chain; a zero value is held rather than wrapped.
  always_comb begin
    dec_value = cur_reg;
    if (!is_zero(cur_reg)) begin
      if (cur_reg.cs != '0) begin
        dec_value.cs = cur_reg.cs - 1'b1;
      end else begin
        dec_value.cs = CS_MAX;
        if (cur_reg.sec != '0) begin
          dec_value.sec = cur_reg.sec - 1'b1;
        end else begin
          dec_value.sec = SM_MAX;
          if (cur_reg.min != '0) begin
            dec_value.min = cur_reg.min - 1'b1;
          end else begin
            dec_value.min  = SM_MAX;
            dec_value.hour = cur_reg.hour - 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    alarm_next = 1'b0;
    if (bus.load) begin
      cur_next   = load_value;
      state_next = is_zero(load_value) ? ST_EXPIRED : run_state;
    end else begin
      case (state_reg)
        ST_ARMED: state_next = run_state;
        ST_RUNNING: begin
          if (tick) begin
            cur_next = dec_value;
            if (is_zero(dec_value)) begin
              state_next = ST_EXPIRED;
              alarm_next = 1'b1;
            end else begin
              state_next = run_state;
            end
          end else begin
            state_next = run_state;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cur_reg   <= '0;
      alarm_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      alarm_reg <= alarm_next;
    end
  end

  assign bus.epoch   = {cur_reg.hour, cur_reg.min, cur_reg.sec};
  assign bus.m_epoch = cur_reg.cs;
  assign bus.done    = (state_reg == ST_EXPIRED);
  assign bus.alarm   = alarm_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a centisecond-count reference model checked every cycle.
module tb_countdown_timer;

  localparam int CPT = 2;
  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_EXP = 3;

  logic clock;
  logic reset;
  countdown_timer_if bus();

  countdown_timer #(.CLK_PER_TICK(CPT), .HOUR_MAX(63)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining time as a plain centisecond count.
  int m_total, m_pre, m_mode;
  bit m_alarm;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic int sat_total(input logic [17:0] e, input logic [7:0] c);
    int h, mi, s, cs;
    h  = clampi(int'(e[17:12]), 63);
    mi = clampi(int'(e[11:6]), 59);
    s  = clampi(int'(e[5:0]), 59);
    cs = clampi(int'(c), 99);
    return h * 360000 + mi * 6000 + s * 100 + cs;
  endfunction

  function automatic int hms(input int h, input int mi, input int s);
    return (h << 12) | (mi << 6) | s;
  endfunction

  task automatic model_clear();
    m_total = 0;
    m_pre   = 0;
    m_mode  = M_IDLE;
    m_alarm = 0;
  endtask

  task automatic model_step(input bit run_i, input bit load_i,
                            input logic [17:0] le, input logic [7:0] lm);
    bit tick;
    tick    = (m_mode == M_RUN) && (m_pre == CPT - 1);
    m_alarm = 0;
    if (load_i) begin
      m_total = sat_total(le, lm);
      m_pre   = 0;
      m_mode  = (m_total == 0) ? M_EXP : (run_i ? M_RUN : M_ARMED);
    end else if (m_mode == M_RUN) begin
      m_pre = tick ? 0 : m_pre + 1;
      if (tick) m_total--;
      if (m_total == 0) begin
        m_mode  = M_EXP;
        m_alarm = 1;
      end else begin
        m_mode = run_i ? M_RUN : M_ARMED;
      end
    end else if (m_mode == M_ARMED) begin
      m_mode = run_i ? M_RUN : M_ARMED;
    end
  endtask

  task automatic model_compare();
    int h, mi, s, cs;
    h  = m_total / 360000;
    mi = (m_total / 6000) % 60;
    s  = (m_total / 100) % 60;
    cs = m_total % 100;
    check("model_epoch", int'(bus.epoch), hms(h, mi, s));
    check("model_m_epoch", int'(bus.m_epoch), cs);
    check("model_done", int'(bus.done), (m_mode == M_EXP) ? 1 : 0);
    check("model_alarm", int'(bus.alarm), int'(m_alarm));
  endtask

  always @(negedge reset) model_clear();

  always @(posedge clock) begin
    if (reset) begin
      model_step(bus.run, bus.load, bus.load_epoch, bus.load_m_epoch);
      #1;
      if (reset) model_compare();
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called at a negedge; the load is sampled on the following rising edge.
  task automatic do_load(input logic [17:0] e, input logic [7:0] m);
    bus.load         = 1'b1;
    bus.load_epoch   = e;
    bus.load_m_epoch = m;
    @(negedge clock);
    bus.load         = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    reset            = 1'b1;
    bus.run          = 1'b0;
    bus.load         = 1'b0;
    bus.load_epoch   = '0;
    bus.load_m_epoch = '0;
    #1 reset = 1'b0;
    #1;
    check("reset_epoch", int'(bus.epoch), 0);
    check("reset_m_epoch", int'(bus.m_epoch), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_alarm", int'(bus.alarm), 0);
    cyc(2);
    reset = 1'b1;

    // IDLE ignores run
    bus.run = 1'b1;
    cyc(10);
    check("idle_epoch", int'(bus.epoch), 0);
    check("idle_m_epoch", int'(bus.m_epoch), 0);

    // 00:00:01.00 down to zero
    do_load(18'(hms(0, 0, 1)), 8'd0);
    cyc(4);
    check("two_ticks_m_epoch", int'(bus.m_epoch), 98);
    check("two_ticks_epoch", int'(bus.epoch), 0);
    cyc(195);
    check("pre_expiry_m_epoch", int'(bus.m_epoch), 1);
    check("pre_expiry_alarm", int'(bus.alarm), 0);
    cyc(1);
    check("expiry_alarm", int'(bus.alarm), 1);
    check("expiry_done", int'(bus.done), 1);
    check("expiry_m_epoch", int'(bus.m_epoch), 0);
    cyc(1);
    check("post_expiry_alarm", int'(bus.alarm), 0);
    check("post_expiry_done", int'(bus.done), 1);

    // Full borrow chain
    do_load(18'(hms(1, 0, 0)), 8'd0);
    cyc(2);
    check("borrow_epoch", int'(bus.epoch), hms(0, 59, 59));
    check("borrow_m_epoch", int'(bus.m_epoch), 99);

    // Pause and resume
    do_load(18'(hms(0, 0, 10)), 8'd0);
    cyc(5);
    bus.run = 1'b0;
    cyc(50);
    check("pause_epoch", int'(bus.epoch), hms(0, 0, 9));
    check("pause_m_epoch", int'(bus.m_epoch), 97);
    bus.run = 1'b1;
    cyc(4);
    check("resume_m_epoch", int'(bus.m_epoch), 96);

    // Saturating load while paused
    bus.run = 1'b0;
    do_load(18'h3FFFF, 8'd120);
    check("sat_epoch", int'(bus.epoch), hms(63, 59, 59));
    check("sat_m_epoch", int'(bus.m_epoch), 99);
    check("sat_done", int'(bus.done), 0);
    cyc(3);

    // Zero load expires silently
    bus.run = 1'b1;
    do_load(18'd0, 8'd0);
    check("zero_done", int'(bus.done), 1);
    check("zero_alarm", int'(bus.alarm), 0);
    cyc(5);

    // Load coincident with a tick
    do_load(18'd0, 8'd5);
    cyc(1);
    do_load(18'd0, 8'd50);
    check("load_on_tick_m_epoch", int'(bus.m_epoch), 50);
    check("load_on_tick_alarm", int'(bus.alarm), 0);

    // Load coincident with the expiring tick
    do_load(18'd0, 8'd1);
    cyc(1);
    do_load(18'd0, 8'd3);
    check("load_on_expiry_m_epoch", int'(bus.m_epoch), 3);
    check("load_on_expiry_alarm", int'(bus.alarm), 0);
    check("load_on_expiry_done", int'(bus.done), 0);
    cyc(6);
    check("short_expiry_alarm", int'(bus.alarm), 1);
    check("short_expiry_done", int'(bus.done), 1);
    bus.run = 1'b0;
    cyc(3);
    bus.run = 1'b1;
    cyc(5);
    check("expired_hold_done", int'(bus.done), 1);
    check("expired_hold_m_epoch", int'(bus.m_epoch), 0);
    do_load(18'd0, 8'd10);
    check("reload_done", int'(bus.done), 0);
    check("reload_m_epoch", int'(bus.m_epoch), 10);

    // Asynchronous reset mid-count
    do_load(18'(hms(0, 10, 0)), 8'd0);
    cyc(7);
    #2 reset = 1'b0;
    #1;
    check("async_reset_epoch", int'(bus.epoch), 0);
    check("async_reset_m_epoch", int'(bus.m_epoch), 0);
    check("async_reset_done", int'(bus.done), 0);
    check("async_reset_alarm", int'(bus.alarm), 0);
    cyc(2);
    reset = 1'b1;
    cyc(10);
    check("post_reset_epoch", int'(bus.epoch), 0);
    check("post_reset_m_epoch", int'(bus.m_epoch), 0);
    check("post_reset_done", int'(bus.done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
